multi_cycle_controller: RTL and testbench

- Control FSM for the multi-cycle MIPS-subset CPU.
- Sequences one shared ALU, one unified instruction/data memory, the register file and PC/IR/ALUOut registers through FETCH, DECODE, EXEC, MEM and WB.
- Issues per-state datapath enables and mux selects.
- Waits on a variable-latency memory handshake and traps on illegal encodings or memory timeout.

---
 rtl/multi_cycle_controller.sv | 128 ++++++++++++
 tb/tb_multi_cycle_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: FSM sequencing a multi-cycle MIPS-subset datapath through
// FETCH/DECODE/EXEC/MEM/WB with a memory-wait timeout and a sticky ERROR trap.
module multi_cycle_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic                 ir_we,
    output logic                 iord,
    output logic                 mem_re,
    output logic                 mem_we,
    output logic                 reg_we,
    output logic [1:0]           reg_dst,
    output logic [1:0]           mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [3:0]           alu_op,
    output logic                 sign_ext,
    output logic [2:0]           state,
    output logic                 error,
    output logic [CNT_WIDTH-1:0] instr_count
);
    localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, ERROR = 3'd5;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_XOR = 4'd4,
                           ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_LUI = 4'd8;
    logic [2:0] next;
    logic [7:0] wait_cnt;
    logic [3:0] funct_op, imm_op;
    logic r_type, i_alu, is_lw, is_sw, is_mem, is_br, is_j, is_jal, legal_funct, legal, waiting, timeout;
    assign r_type   = opcode == 6'h00;
    assign is_j     = opcode == 6'h02;
    assign is_jal   = opcode == 6'h03;
    assign is_br    = opcode[5:1] == 5'b00010;
    assign i_alu    = opcode == 6'h08 || opcode == 6'h0a || opcode[5:2] == 4'b0011;
    assign is_lw    = opcode == 6'h23;
    assign is_sw    = opcode == 6'h2b;
    assign is_mem   = is_lw | is_sw;
    assign legal    = (r_type & legal_funct) | i_alu | is_mem | is_br;
    assign sign_ext = opcode == 6'h08 || opcode == 6'h0a || is_mem || is_br;
    assign error    = state == ERROR;
    assign waiting  = (state == FETCH || state == MEM) && !mem_ready;
    assign timeout  = waiting && wait_cnt == 8'(MEM_TIMEOUT - 1);
    assign imm_op   = opcode == 6'h0a ? ALU_SLT : opcode == 6'h0c ? ALU_AND : opcode == 6'h0d ? ALU_OR :
                      opcode == 6'h0e ? ALU_XOR : opcode == 6'h0f ? ALU_LUI : ALU_ADD;
    always_comb begin
        funct_op    = ALU_ADD;
        legal_funct = 1'b1;
        case (funct)
            6'h20:   funct_op = ALU_ADD;
            6'h22:   funct_op = ALU_SUB;
            6'h24:   funct_op = ALU_AND;
            6'h25:   funct_op = ALU_OR;
            6'h26:   funct_op = ALU_XOR;
            6'h2a:   funct_op = ALU_SLT;
            6'h00:   funct_op = ALU_SLL;
            6'h02:   funct_op = ALU_SRL;
            default: legal_funct = 1'b0;
        endcase
    end
    always_comb begin
        {pc_we, ir_we, iord, mem_re, mem_we, reg_we, alu_src_a} = '0;
        {pc_src, reg_dst, mem_to_reg, alu_src_b} = '0;
        alu_op = ALU_ADD;
        next   = state;
        case (state)
            FETCH: begin
                mem_re    = 1'b1;
                alu_src_b = 2'b01;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
                next      = mem_ready ? DECODE : timeout ? ERROR : FETCH;
            end
            DECODE: begin
                alu_src_b  = 2'b11;
                pc_we      = is_j | is_jal;
                pc_src     = (is_j | is_jal) ? 2'b10 : 2'b00;
                reg_we     = is_jal;
                reg_dst    = is_jal ? 2'b10 : 2'b00;
                mem_to_reg = is_jal ? 2'b10 : 2'b00;
                next       = (is_j | is_jal) ? FETCH : legal ? EXEC : ERROR;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = (r_type | is_br) ? 2'b00 : 2'b10;
                alu_op    = r_type ? funct_op : is_br ? ALU_SUB : i_alu ? imm_op : ALU_ADD;
                pc_src    = is_br ? 2'b01 : 2'b00;
                // opcode[0] distinguishes bne from beq
                pc_we     = is_br & (zero ^ opcode[0]);
                next      = is_br ? FETCH : is_mem ? MEM : WB;
            end
            MEM: begin
                iord   = 1'b1;
                mem_re = is_lw;
                mem_we = is_sw;
                next   = mem_ready ? (is_lw ? WB : FETCH) : timeout ? ERROR : MEM;
            end
            WB: begin
                reg_we     = 1'b1;
                reg_dst    = r_type ? 2'b01 : 2'b00;
                mem_to_reg = is_lw ? 2'b01 : 2'b00;
                next       = FETCH;
            end
            ERROR:   next = ERROR;
            default: next = ERROR;
        endcase
        if (!rst) {pc_we, ir_we, mem_re, mem_we, reg_we} = '0;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FETCH;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            state    <= next;
            wait_cnt <= (next != state && (next == FETCH || next == MEM)) ? 8'd0 :
                        waiting ? wait_cnt + 8'd1 : wait_cnt;
            if (next == FETCH && state != FETCH)
                instr_count <= instr_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: randomized instruction stream against an instruction-level
// reference model; expected per-cycle outputs are queued and checked by a separate monitor.
module tb_multi_cycle_controller;
    localparam int TO = 15;
    typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_J, K_JAL, K_BAD} kind_t;
    typedef struct packed {
        logic [2:0]  st;
        logic        pc_we;
        logic [1:0]  pc_src;
        logic        ir_we;
        logic        iord;
        logic        mem_re;
        logic        mem_we;
        logic        reg_we;
        logic [1:0]  reg_dst;
        logic [1:0]  mem_to_reg;
        logic        a;
        logic [1:0]  b;
        logic [3:0]  op;
        logic        sx;
        logic        err;
        logic [31:0] cnt;
    } exp_t;

    logic clk = 0, rst = 0, zero = 0, mem_ready = 0;
    logic [5:0] opcode = 0, funct = 0;
    logic pc_we, ir_we, iord, mem_re, mem_we, reg_we, alu_src_a, sign_ext, error;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
    logic [3:0] alu_op;
    logic [2:0] state;
    logic [31:0] instr_count;

    exp_t q[$];
    int checks = 0, failures = 0, cyc_n = 0;
    int unsigned cnt_m = 0;
    bit in_err = 0;

    multi_cycle_controller #(.MEM_TIMEOUT(TO), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .iord(iord), .mem_re(mem_re), .mem_we(mem_we),
        .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .sign_ext(sign_ext), .state(state), .error(error),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic int r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 0;
            6'b100010: return 1;
            6'b100100: return 2;
            6'b100101: return 3;
            6'b100110: return 4;
            6'b101010: return 5;
            6'b000000: return 6;
            6'b000010: return 7;
            default:   return -1;
        endcase
    endfunction

    function automatic int i_alu(input logic [5:0] op);
        case (op)
            6'b001000: return 0;
            6'b001010: return 5;
            6'b001100: return 2;
            6'b001101: return 3;
            6'b001110: return 4;
            6'b001111: return 8;
            default:   return -1;
        endcase
    endfunction

    function automatic kind_t kind_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) return r_alu(fn) >= 0 ? K_R : K_BAD;
        if (i_alu(op) >= 0) return K_I;
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100, 6'b000101: return K_BR;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            default:   return K_BAD;
        endcase
    endfunction

    function automatic logic sx_of(input logic [5:0] op);
        return op inside {6'b001000, 6'b001010, 6'b100011, 6'b101011, 6'b000100, 6'b000101};
    endfunction

    function automatic exp_t base(input logic [2:0] s);
        exp_t e = '0;
        e.st = s;
        return e;
    endfunction

    task automatic cyc(input exp_t e, input logic mr);
        mem_ready = mr;
        e.sx  = sx_of(opcode);
        e.err = e.st == 3'd5;
        e.cnt = cnt_m;
        if (!rst) {e.pc_we, e.ir_we, e.mem_re, e.mem_we, e.reg_we} = '0;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // A memory phase: d cycles waiting, then the completing cycle, unless the wait times out.
    task automatic mem_phase(input exp_t w, input exp_t done, input int d, output bit to);
        to = d >= TO;
        for (int i = 0; i < (to ? TO : d); i++) cyc(w, 1'b0);
        if (!to) cyc(done, 1'b1);
        else in_err = 1;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int fd, input int md);
        exp_t e, w;
        bit to;
        kind_t k = kind_of(op, fn);
        opcode = op; funct = fn; zero = z;
        w = base(3'd0); w.mem_re = 1; w.b = 2'd1;
        e = w; e.ir_we = 1; e.pc_we = 1;
        mem_phase(w, e, fd, to);
        if (to) return;
        e = base(3'd1); e.b = 2'd3;
        if (k == K_J || k == K_JAL) begin
            e.pc_we = 1; e.pc_src = 2'd2;
            if (k == K_JAL) begin e.reg_we = 1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; end
            cyc(e, rnd());
            cnt_m++;
            return;
        end
        cyc(e, rnd());
        if (k == K_BAD) begin in_err = 1; return; end
        e = base(3'd2); e.a = 1;
        case (k)
            K_R: e.op = 4'(r_alu(fn));
            K_I: begin e.b = 2'd2; e.op = 4'(i_alu(op)); end
            K_BR: begin e.op = 4'd1; e.pc_src = 2'd1; e.pc_we = (op == 6'b000100) ? z : !z; end
            default: e.b = 2'd2;
        endcase
        cyc(e, rnd());
        if (k == K_BR) begin cnt_m++; return; end
        if (k == K_LW || k == K_SW) begin
            w = base(3'd3); w.iord = 1; w.mem_re = k == K_LW; w.mem_we = k == K_SW;
            mem_phase(w, w, md, to);
            if (to) return;
            if (k == K_SW) begin cnt_m++; return; end
        end
        e = base(3'd4); e.reg_we = 1;
        e.reg_dst = k == K_R ? 2'd1 : 2'd0;
        e.mem_to_reg = k == K_LW ? 2'd1 : 2'd0;
        cyc(e, rnd());
        cnt_m++;
    endtask

    task automatic err_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            zero = rnd(); opcode = 6'($urandom);
            cyc(base(3'd5), rnd());
        end
    endtask

    task automatic reset_from(input exp_t e);
        rst = 0;
        cyc(e, rnd());
        rst = 1; cnt_m = 0; in_err = 0;
    endtask

    always @(negedge clk) begin
        exp_t e, a;
        cyc_n++;
        if (q.size() != 0) begin
            e = q.pop_front();
            a = '{st: state, pc_we: pc_we, pc_src: pc_src, ir_we: ir_we, iord: iord, mem_re: mem_re,
                  mem_we: mem_we, reg_we: reg_we, reg_dst: reg_dst, mem_to_reg: mem_to_reg,
                  a: alu_src_a, b: alu_src_b, op: alu_op, sx: sign_ext, err: error, cnt: instr_count};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cycle%0d outputs act st=%0d pcwe=%b pcsrc=%0d irwe=%b iord=%b re=%b we=%b rwe=%b dst=%0d m2r=%0d a=%b b=%0d op=%0d sx=%b err=%b cnt=%0d | exp st=%0d pcwe=%b pcsrc=%0d irwe=%b iord=%b re=%b we=%b rwe=%b dst=%0d m2r=%0d a=%b b=%0d op=%0d sx=%b err=%b cnt=%0d",
                    cyc_n, a.st, a.pc_we, a.pc_src, a.ir_we, a.iord, a.mem_re, a.mem_we, a.reg_we, a.reg_dst,
                    a.mem_to_reg, a.a, a.b, a.op, a.sx, a.err, a.cnt, e.st, e.pc_we, e.pc_src, e.ir_we, e.iord,
                    e.mem_re, e.mem_we, e.reg_we, e.reg_dst, e.mem_to_reg, e.a, e.b, e.op, e.sx, e.err, e.cnt);
            end
        end
    end

    initial begin
        exp_t e;
        logic [5:0] op, fn;
        logic [5:0] legal_ops [12] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23};
        logic [5:0] legal_fns [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2a, 6'h00, 6'h02};
        rst = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        instr(6'h00, 6'h20, 0, 0, 0);
        instr(6'h23, 6'h00, 0, 0, 0);
        instr(6'h2b, 6'h00, 0, 0, 0);
        instr(6'h04, 6'h00, 1, 0, 0);
        instr(6'h04, 6'h00, 0, 0, 0);
        instr(6'h05, 6'h00, 0, 0, 0);
        instr(6'h02, 6'h00, 0, 0, 0);
        instr(6'h03, 6'h00, 0, 0, 0);
        instr(6'h0f, 6'h00, 0, 3, 0);
        instr(6'h23, 6'h00, 0, 0, TO - 1);
        instr(6'h00, 6'h00, 0, TO, 0);
        err_cycles(3);
        reset_from(base(3'd5));
        instr(6'h3f, 6'h00, 0, 0, 0);
        err_cycles(2);
        reset_from(base(3'd5));
        instr(6'h2b, 6'h00, 0, 0, TO);
        err_cycles(2);
        reset_from(base(3'd5));
        // sw aborted by reset while its memory write is pending
        instr(6'h08, 6'h00, 0, 0, 0);
        opcode = 6'h2b; zero = 0;
        e = base(3'd0); e.mem_re = 1; e.b = 2'd1; e.ir_we = 1; e.pc_we = 1; cyc(e, 1'b1);
        e = base(3'd1); e.b = 2'd3; cyc(e, 1'b0);
        e = base(3'd2); e.a = 1; e.b = 2'd2; cyc(e, 1'b0);
        e = base(3'd3); e.iord = 1; e.mem_we = 1; cyc(e, 1'b0);
        reset_from(e);
        e = base(3'd0); e.mem_re = 1; e.b = 2'd1; cyc(e, 1'b0);
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                do begin op = 6'($urandom); fn = 6'($urandom); end while (kind_of(op, fn) != K_BAD);
            end else begin
                op = $urandom_range(0, 5) == 0 ? 6'h2b : legal_ops[$urandom_range(0, 11)];
                fn = legal_fns[$urandom_range(0, 7)];
            end
            instr(op, fn, rnd(),
                  $urandom_range(0, 29) == 0 ? TO : $urandom_range(0, 3),
                  $urandom_range(0, 29) == 0 ? TO : $urandom_range(0, 3));
            if (in_err) begin
                err_cycles(2);
                reset_from(base(3'd5));
            end
        end
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
